pixel_iter_ctrl: RTL and testbench

//  Per-pixel iteration sequencer for the Julia worker. Accepts one pixel job and loads the
//  z^2+c datapath. Issues one step per iteration and counts completed steps. Stops on escape
//  or when the count reaches max_iter, then presents the iteration count downstream.

---
 rtl/julia_pkg.sv | 16 +
 rtl/iter_counter.sv | 31 +++
 rtl/pixel_iter_ctrl.sv | 119 +++++++++++
 tb/tb_pixel_iter_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/julia_pkg.sv
// Shared types and default widths for the Julia worker.
// Imported by the iteration controller and its counter.
package julia_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    DONE
  } iter_state_t;

  localparam int NUM_CNT_BITS_DEF = 8;
  localparam int COORD_W_DEF      = 16;

endpackage

// File: rtl/iter_counter.sv
// Clear/enable iteration counter for one pixel.
// Flags when the next count would equal the limit.
module iter_counter #(
  parameter int W = julia_pkg::NUM_CNT_BITS_DEF
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic [W-1:0] next,
  output logic         at_limit
);

  logic [W-1:0] count;

  assign next     = count + W'(1);
  assign at_limit = (next == limit);

  // Count completed steps; clear wins over enable.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= next;
    end
  end

endmodule

// File: rtl/pixel_iter_ctrl.sv
// Per-pixel iteration sequencer for the Julia worker.
// Loads the datapath, issues steps, reports count/escape.
module pixel_iter_ctrl
  import julia_pkg::*;
#(
  parameter int NUM_CNT_BITS = NUM_CNT_BITS_DEF,
  parameter int COORD_W      = COORD_W_DEF
) (
  input  logic                    clk,
  input  logic                    n_rst,
  input  logic                    job_valid,
  output logic                    job_ready,
  input  logic [COORD_W-1:0]      job_x,
  input  logic [COORD_W-1:0]      job_y,
  input  logic [NUM_CNT_BITS-1:0] max_iter,
  output logic                    dp_load,
  output logic                    step_start,
  input  logic                    step_done,
  input  logic                    escaped,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic [COORD_W-1:0]      res_x,
  output logic [COORD_W-1:0]      res_y,
  output logic [NUM_CNT_BITS-1:0] res_iter,
  output logic                    res_escaped
);

  iter_state_t state;
  iter_state_t state_nxt;

  logic [COORD_W-1:0]      x_q;
  logic [COORD_W-1:0]      y_q;
  logic [NUM_CNT_BITS-1:0] max_q;
  logic [NUM_CNT_BITS-1:0] iter_q;
  logic                    esc_q;

  logic [NUM_CNT_BITS-1:0] cnt_next;
  logic                    at_limit;
  logic                    accept;
  logic                    wdone;
  logic                    finish;

  assign job_ready  = (state == IDLE);
  assign dp_load    = (state == LOAD);
  assign step_start = (state == ISSUE);
  assign res_valid  = (state == DONE);

  assign accept = job_valid && job_ready;
  assign wdone  = (state == WAIT) && step_done;
  assign finish = escaped || at_limit;

  assign res_x       = x_q;
  assign res_y       = y_q;
  assign res_iter    = iter_q;
  assign res_escaped = esc_q;

  iter_counter #(
    .W(NUM_CNT_BITS)
  ) u_cnt (
    .clk     (clk),
    .n_rst   (n_rst),
    .clr     (accept),
    .en      (wdone && !finish),
    .limit   (max_q),
    .next    (cnt_next),
    .at_limit(at_limit)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode; step_done only matters in WAIT.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:  if (job_valid) state_nxt = LOAD;
      LOAD:  state_nxt = (max_q == '0) ? DONE : ISSUE;
      ISSUE: state_nxt = WAIT;
      WAIT: begin
        if (step_done) state_nxt = finish ? DONE : ISSUE;
      end
      DONE:  if (res_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Job latch and result capture; escape beats the limit.
  always_ff @(posedge clk) begin
    if (!n_rst) begin
      x_q    <= '0;
      y_q    <= '0;
      max_q  <= '0;
      iter_q <= '0;
      esc_q  <= 1'b0;
    end else begin
      if (accept) begin
        x_q    <= job_x;
        y_q    <= job_y;
        max_q  <= max_iter;
        iter_q <= '0;
        esc_q  <= 1'b0;
      end
      if (wdone && escaped) begin
        iter_q <= cnt_next;
        esc_q  <= 1'b1;
      end else if (wdone && at_limit) begin
        iter_q <= max_q;
        esc_q  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pixel_iter_ctrl.sv
// Self-checking bench for pixel_iter_ctrl.
// Scoreboard of expected results plus a datapath model.
module tb_pixel_iter_ctrl;

  localparam int CW = 16;
  localparam int NB = 8;

  typedef struct packed {
    logic [CW-1:0] x;
    logic [CW-1:0] y;
    logic [NB-1:0] it;
    logic          esc;
  } res_t;

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic          job_valid = 1'b0;
  logic          job_ready;
  logic [CW-1:0] job_x = '0;
  logic [CW-1:0] job_y = '0;
  logic [NB-1:0] max_iter = '0;
  logic          dp_load;
  logic          step_start;
  logic          step_done = 1'b0;
  logic          escaped = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic [CW-1:0] res_x;
  logic [CW-1:0] res_y;
  logic [NB-1:0] res_iter;
  logic          res_escaped;

  res_t exp_q[$];
  res_t exp_r;
  res_t act;
  res_t hold;

  int n_checks = 0;
  int n_fail   = 0;
  int step_cnt = 0;
  int load_cnt = 0;
  int pend     = 0;
  int base     = 0;
  int lbase    = 0;
  int esc_on   = 0;
  int dp_lat   = 1;
  bit to;

  pixel_iter_ctrl #(
    .NUM_CNT_BITS(NB),
    .COORD_W     (CW)
  ) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .job_valid  (job_valid),
    .job_ready  (job_ready),
    .job_x      (job_x),
    .job_y      (job_y),
    .max_iter   (max_iter),
    .dp_load    (dp_load),
    .step_start (step_start),
    .step_done  (step_done),
    .escaped    (escaped),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_x      (res_x),
    .res_y      (res_y),
    .res_iter   (res_iter),
    .res_escaped(res_escaped)
  );

  always #5 clk = ~clk;

  // Datapath model: answers each step after dp_lat cycles.
  always @(negedge clk) begin
    step_done = 1'b0;
    escaped   = 1'b0;
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) begin
        step_done = 1'b1;
        escaped   = ((step_cnt - base) == esc_on);
      end
    end
    if (step_start) begin
      step_cnt = step_cnt + 1;
      pend     = dp_lat;
    end
    if (dp_load) load_cnt = load_cnt + 1;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one job, record expectation; returns at cycle T+1.
  task automatic start_job(input logic [CW-1:0] x,
                           input logic [CW-1:0] y,
                           input logic [NB-1:0] mx,
                           input int esc_step,
                           input res_t e);
    tick();
    base      = step_cnt;
    lbase     = load_cnt;
    esc_on    = esc_step;
    job_valid = 1'b1;
    job_x     = x;
    job_y     = y;
    max_iter  = mx;
    exp_q.push_back(e);
    tick();
    job_valid = 1'b0;
    job_x     = CW'($urandom);
    job_y     = CW'($urandom);
    max_iter  = NB'($urandom);
  endtask

  task automatic wait_res(input int bound, output bit tmo);
    int n = 0;
    while (!res_valid && n < bound) begin
      tick();
      n++;
    end
    tmo = !res_valid;
  endtask

  task automatic ack();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    tick();
    tick();
    n_rst = 1'b1;
    n_checks++;
    if ({job_ready, dp_load, step_start, res_valid} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_ctl: got %b expected 1000",
               {job_ready, dp_load, step_start, res_valid});
    end
    act = {res_x, res_y, res_iter, res_escaped};
    n_checks++;
    if (act !== '0) begin
      n_fail++;
      $display("FAIL reset_res: got %h expected 0", act);
    end
  endtask

  task automatic test_limit();
    start_job(16'd12, 16'd34, 8'd5, 0, {16'd12, 16'd34, 8'd5, 1'b0});
    n_checks++;
    if (dp_load !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_load: got %b expected 1", dp_load);
    end
    tick();
    n_checks++;
    if (step_start !== 1'b1) begin
      n_fail++;
      $display("FAIL limit_first_step: got %b expected 1", step_start);
    end
    wait_res(200, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL limit_timeout: got no res_valid expected res_valid");
    end
    act   = {res_x, res_y, res_iter, res_escaped};
    exp_r = exp_q.pop_front();
    n_checks++;
    if (act !== exp_r) begin
      n_fail++;
      $display("FAIL limit_res: got %h expected %h", act, exp_r);
    end
    n_checks++;
    if (step_cnt - base !== 5) begin
      n_fail++;
      $display("FAIL limit_steps: got %0d expected 5", step_cnt - base);
    end
    ack();
    n_checks++;
    if ({res_valid, job_ready} !== 2'b01) begin
      n_fail++;
      $display("FAIL limit_ack: got %b expected 01", {res_valid, job_ready});
    end
  endtask

  task automatic test_escape();
    start_job(16'd100, 16'd200, 8'd10, 3, {16'd100, 16'd200, 8'd3, 1'b1});
    wait_res(200, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL esc_timeout: got no res_valid expected res_valid");
    end
    act   = {res_x, res_y, res_iter, res_escaped};
    exp_r = exp_q.pop_front();
    n_checks++;
    if (act !== exp_r) begin
      n_fail++;
      $display("FAIL esc_res: got %h expected %h", act, exp_r);
    end
    n_checks++;
    if (step_cnt - base !== 3) begin
      n_fail++;
      $display("FAIL esc_steps: got %0d expected 3", step_cnt - base);
    end
    ack();
  endtask

  task automatic test_zero();
    start_job(16'h0abc, 16'h0def, 8'd0, 0, {16'h0abc, 16'h0def, 8'd0, 1'b0});
    n_checks++;
    if ({dp_load, res_valid} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_t1: got %b expected 10", {dp_load, res_valid});
    end
    tick();
    n_checks++;
    if ({res_valid, step_start} !== 2'b10) begin
      n_fail++;
      $display("FAIL zero_t2: got %b expected 10", {res_valid, step_start});
    end
    act   = {res_x, res_y, res_iter, res_escaped};
    exp_r = exp_q.pop_front();
    n_checks++;
    if (act !== exp_r) begin
      n_fail++;
      $display("FAIL zero_res: got %h expected %h", act, exp_r);
    end
    n_checks++;
    if ({step_cnt - base, load_cnt - lbase} !== {32'd0, 32'd1}) begin
      n_fail++;
      $display("FAIL zero_counts: got steps %0d loads %0d expected 0 1",
               step_cnt - base, load_cnt - lbase);
    end
    ack();
  endtask

  task automatic test_back_to_back();
    start_job(16'd1, 16'd2, 8'd2, 0, {16'd1, 16'd2, 8'd2, 1'b0});
    wait_res(200, to);
    n_checks++;
    if (to) begin
      n_fail++;
      $display("FAIL bp_timeout: got no res_valid expected res_valid");
    end
    hold      = {res_x, res_y, res_iter, res_escaped};
    job_valid = 1'b1;
    job_x     = 16'd7;
    job_y     = 16'd8;
    max_iter  = 8'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      act = {res_x, res_y, res_iter, res_escaped};
      n_checks++;
      if (act !== hold || {res_valid, job_ready} !== 2'b10) begin
        n_fail++;
        $display("FAIL bp_hold%0d: got %h v%b r%b expected %h v1 r0",
                 i, act, res_valid, job_ready, hold);
      end
    end
    exp_r = exp_q.pop_front();
    n_checks++;
    if (hold !== exp_r) begin
      n_fail++;
      $display("FAIL bp_res_a: got %h expected %h", hold, exp_r);
    end
    exp_q.push_back({16'd7, 16'd8, 8'd1, 1'b0});
    base   = step_cnt;
    esc_on = 0;
    ack();
    n_checks++;
    if (job_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ready: got %b expected 1", job_ready);
    end
    tick();
    job_valid = 1'b0;
    n_checks++;
    if ({dp_load, job_ready} !== 2'b10) begin
      n_fail++;
      $display("FAIL b2b_accept: got %b expected 10", {dp_load, job_ready});
    end
    wait_res(200, to);
    act   = {res_x, res_y, res_iter, res_escaped};
    exp_r = exp_q.pop_front();
    n_checks++;
    if (to || act !== exp_r) begin
      n_fail++;
      $display("FAIL b2b_res_b: got %h expected %h", act, exp_r);
    end
    ack();
  endtask

  task automatic test_boundary();
    start_job(16'hffff, 16'h0000, 8'd255, 0, {16'hffff, 16'h0000, 8'd255, 1'b0});
    wait_res(1200, to);
    act   = {res_x, res_y, res_iter, res_escaped};
    exp_r = exp_q.pop_front();
    n_checks++;
    if (to || act !== exp_r) begin
      n_fail++;
      $display("FAIL max255_res: got %h expected %h", act, exp_r);
    end
    n_checks++;
    if (step_cnt - base !== 255) begin
      n_fail++;
      $display("FAIL max255_steps: got %0d expected 255", step_cnt - base);
    end
    ack();
    start_job(16'd5, 16'd6, 8'd1, 1, {16'd5, 16'd6, 8'd1, 1'b1});
    wait_res(200, to);
    act   = {res_x, res_y, res_iter, res_escaped};
    exp_r = exp_q.pop_front();
    n_checks++;
    if (to || act !== exp_r) begin
      n_fail++;
      $display("FAIL max1_esc_res: got %h expected %h", act, exp_r);
    end
    ack();
    start_job(16'd9, 16'd9, 8'd4, 4, {16'd9, 16'd9, 8'd4, 1'b1});
    wait_res(200, to);
    act   = {res_x, res_y, res_iter, res_escaped};
    exp_r = exp_q.pop_front();
    n_checks++;
    if (to || act !== exp_r) begin
      n_fail++;
      $display("FAIL last_step_esc_res: got %h expected %h", act, exp_r);
    end
    ack();
  endtask

  task automatic test_reset_mid();
    dp_lat = 4;
    start_job(16'd3, 16'd4, 8'd5, 0, '0);
    exp_q.delete();
    tick();
    tick();
    n_rst = 1'b0;
    tick();
    n_rst = 1'b1;
    n_checks++;
    if ({job_ready, res_valid, step_start, dp_load} !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_mid: got %b expected 1000",
               {job_ready, res_valid, step_start, dp_load});
    end
    for (int i = 0; i < 8; i++) begin
      tick();
      n_checks++;
      if ({job_ready, res_valid, step_start, dp_load} !== 4'b1000) begin
        n_fail++;
        $display("FAIL rst_late_done%0d: got %b expected 1000",
                 i, {job_ready, res_valid, step_start, dp_load});
      end
    end
    dp_lat = 1;
    start_job(16'd21, 16'd22, 8'd2, 0, {16'd21, 16'd22, 8'd2, 1'b0});
    wait_res(200, to);
    act   = {res_x, res_y, res_iter, res_escaped};
    exp_r = exp_q.pop_front();
    n_checks++;
    if (to || act !== exp_r) begin
      n_fail++;
      $display("FAIL rst_recover_res: got %h expected %h", act, exp_r);
    end
    ack();
  endtask

  initial begin
    test_reset();
    test_limit();
    test_escape();
    test_zero();
    test_back_to_back();
    test_boundary();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got %0d expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
